// File: rtl/hc_rx_arb_pkg.sv
// Shared encodings and types for the host-controller RX port arbiter.
// The FSM state, grants and FIFO words are described here so checkers can bind to named fields.
package hc_rx_arb_pkg;

   localparam int RX_WORD_W     = 16;
   localparam int RX_FIFO_DEPTH = 4;
   localparam int RX_ADDR_W     = 2;

   localparam logic [2:0] ST_INIT   = 3'd0;
   localparam logic [2:0] ST_IDLE   = 3'd1;
   localparam logic [2:0] ST_GETPKT = 3'd2;
   localparam logic [2:0] ST_DIRECT = 3'd3;

   typedef struct packed {
      logic [7:0] cntl;
      logic [7:0] data;
   } rx_word_t;

   // Registered arbiter state: FSM encoding plus the two grants it drives.
   typedef struct packed {
      logic [2:0] state;
      logic       getPacketGnt;
      logic       directCntlGnt;
   } arb_state_t;

   localparam arb_state_t ARB_RESET = '{state: ST_INIT, getPacketGnt: 1'b0, directCntlGnt: 1'b0};

endpackage

// File: rtl/hc_rx_byte_fifo.sv
// Small first-word-fall-through FIFO of {cntl,data} words with synchronous flush.
// The head word is visible on rdWord whenever count is non-zero.
module hc_rx_byte_fifo
   import hc_rx_arb_pkg::*;
#(
   parameter int DEPTH  = RX_FIFO_DEPTH,
   parameter int ADDR_W = RX_ADDR_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic                 pop,
   input  logic                 flush,
   input  logic [RX_WORD_W-1:0] wrWord,
   output logic [RX_WORD_W-1:0] rdWord,
   output logic [ADDR_W:0]      count,
   output logic                 full
);

   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

   logic [RX_WORD_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0]    wrPtr;
   logic [ADDR_W-1:0]    rdPtr;
   logic                 doPush;
   logic                 doPop;

   assign full   = (count == DEPTH_CNT);
   assign doPop  = pop && (count != '0);
   // A full FIFO still takes a word when the head leaves in the same cycle.
   assign doPush = push && (!full || doPop);
   assign rdWord = mem[rdPtr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: the head is only observed while count is non-zero.
   always_ff @(posedge clk) begin
      if (doPush && !flush && !rst) mem[wrPtr] <= wrWord;
   end

endmodule

// File: rtl/hc_rx_port_arbiter.sv
// RX port arbiter: buffers received bytes and grants them to getPacket (priority) or directCntl.
// Handshake: a consumer sees RxValid only while granted; a byte leaves the FIFO on a cycle where RxValid && RdEn.
module hc_rx_port_arbiter
   import hc_rx_arb_pkg::*;
#(
   parameter int FIFO_DEPTH = RX_FIFO_DEPTH,
   parameter int ADDR_W     = RX_ADDR_W
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] RxPortData,
   input  logic [7:0] RxPortCntl,
   input  logic       RxPortDataValid,
   input  logic       getPacketReq,
   input  logic       getPacketRdEn,
   input  logic       directCntlReq,
   input  logic       directCntlRdEn,
   output logic       getPacketGnt,
   output logic       getPacketRxValid,
   output logic [7:0] getPacketRxData,
   output logic [7:0] getPacketRxCntl,
   output logic       directCntlGnt,
   output logic       directCntlRxValid,
   output logic [7:0] directCntlRxData,
   output logic [7:0] directCntlRxCntl,
   output logic       rxOverflow
);

   arb_state_t      arbQ;
   rx_word_t        headWord;
   rx_word_t        inWord;
   logic [ADDR_W:0] fifoCount;
   logic            fifoFull;
   logic            haveData;
   logic            fifoPush;
   logic            fifoPop;
   logic            flush;

   assign getPacketGnt  = arbQ.getPacketGnt;
   assign directCntlGnt = arbQ.directCntlGnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         arbQ <= ARB_RESET;
      end else begin
         case (arbQ.state)
            ST_INIT: arbQ.state <= ST_IDLE;
            ST_IDLE: begin
               if (getPacketReq) begin
                  arbQ.state        <= ST_GETPKT;
                  arbQ.getPacketGnt <= 1'b1;
               end else if (directCntlReq) begin
                  arbQ.state         <= ST_DIRECT;
                  arbQ.directCntlGnt <= 1'b1;
               end
            end
            ST_GETPKT: begin
               if (!getPacketReq) begin
                  arbQ.state        <= ST_IDLE;
                  arbQ.getPacketGnt <= 1'b0;
               end
            end
            ST_DIRECT: begin
               if (!directCntlReq) begin
                  arbQ.state         <= ST_IDLE;
                  arbQ.directCntlGnt <= 1'b0;
               end
            end
            default: begin
               arbQ.state         <= ST_IDLE;
               arbQ.getPacketGnt  <= 1'b0;
               arbQ.directCntlGnt <= 1'b0;
            end
         endcase
      end
   end

   // Releasing a grant discards whatever the owner left behind.
   assign flush = ((arbQ.state == ST_GETPKT) && !getPacketReq) ||
                  ((arbQ.state == ST_DIRECT) && !directCntlReq);

   assign haveData          = (fifoCount != '0);
   assign getPacketRxValid  = arbQ.getPacketGnt && haveData;
   assign directCntlRxValid = arbQ.directCntlGnt && haveData;

   assign fifoPop  = (getPacketRxValid && getPacketRdEn) || (directCntlRxValid && directCntlRdEn);
   assign fifoPush = RxPortDataValid && (!fifoFull || fifoPop) && !flush;
   assign inWord   = '{cntl: RxPortCntl, data: RxPortData};

   hc_rx_byte_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push   (fifoPush),
      .pop    (fifoPop),
      .flush  (flush),
      .wrWord (inWord),
      .rdWord (headWord),
      .count  (fifoCount),
      .full   (fifoFull)
   );

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rxOverflow <= 1'b0;
      end else if (RxPortDataValid && fifoFull && !fifoPop) begin
         rxOverflow <= 1'b1;
      end
   end

   assign getPacketRxData   = getPacketRxValid  ? headWord.data : 8'h00;
   assign getPacketRxCntl   = getPacketRxValid  ? headWord.cntl : 8'h00;
   assign directCntlRxData  = directCntlRxValid ? headWord.data : 8'h00;
   assign directCntlRxCntl  = directCntlRxValid ? headWord.cntl : 8'h00;

endmodule

// File: tb/tb_hc_rx_port_arbiter.sv
// Bench for hc_rx_port_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_hc_rx_port_arbiter;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] RxPortData;
   logic [7:0] RxPortCntl;
   logic       RxPortDataValid;
   logic       getPacketReq;
   logic       getPacketRdEn;
   logic       directCntlReq;
   logic       directCntlRdEn;
   logic       getPacketGnt;
   logic       getPacketRxValid;
   logic [7:0] getPacketRxData;
   logic [7:0] getPacketRxCntl;
   logic       directCntlGnt;
   logic       directCntlRxValid;
   logic [7:0] directCntlRxData;
   logic [7:0] directCntlRxCntl;
   logic       rxOverflow;

   int checks   = 0;
   int failures = 0;

   // Model: owner 0 = nobody, 1 = getPacket, 2 = directCntl.
   logic [15:0] exp_q[$];
   int          owner   = 0;
   bit          inInit  = 1'b1;
   bit          expOvf  = 1'b0;

   hc_rx_port_arbiter dut (
      .clk               (clk),
      .rst               (rst),
      .RxPortData        (RxPortData),
      .RxPortCntl        (RxPortCntl),
      .RxPortDataValid   (RxPortDataValid),
      .getPacketReq      (getPacketReq),
      .getPacketRdEn     (getPacketRdEn),
      .directCntlReq     (directCntlReq),
      .directCntlRdEn    (directCntlRdEn),
      .getPacketGnt      (getPacketGnt),
      .getPacketRxValid  (getPacketRxValid),
      .getPacketRxData   (getPacketRxData),
      .getPacketRxCntl   (getPacketRxCntl),
      .directCntlGnt     (directCntlGnt),
      .directCntlRxValid (directCntlRxValid),
      .directCntlRxData  (directCntlRxData),
      .directCntlRxCntl  (directCntlRxCntl),
      .rxOverflow        (rxOverflow)
   );

   always #5 clk = ~clk;

   function automatic logic expValid(int who);
      return (owner == who) && (exp_q.size() != 0);
   endfunction

   function automatic logic [7:0] expData(int who);
      logic [15:0] w;
      if (!expValid(who)) return 8'h00;
      w = exp_q[0];
      return w[7:0];
   endfunction

   function automatic logic [7:0] expCntl(int who);
      logic [15:0] w;
      if (!expValid(who)) return 8'h00;
      w = exp_q[0];
      return w[15:8];
   endfunction

   // Apply one clock edge to the model using the inputs currently driven.
   task automatic modelEdge();
      int oldOwner;
      bit wasInit;
      bit popNow;
      bit relNow;
      oldOwner = owner;
      wasInit  = inInit;
      if (rst) begin
         exp_q.delete();
         owner  = 0;
         inInit = 1'b1;
         expOvf = 1'b0;
      end else begin
         popNow = (exp_q.size() != 0) &&
                  ((oldOwner == 1 && getPacketRdEn) || (oldOwner == 2 && directCntlRdEn));
         relNow = (oldOwner == 1 && !getPacketReq) || (oldOwner == 2 && !directCntlReq);
         if (relNow) begin
            exp_q.delete();
            expOvf = 1'b0;
            owner  = 0;
         end else begin
            if (popNow) void'(exp_q.pop_front());
            if (RxPortDataValid) begin
               if (exp_q.size() < DEPTH) exp_q.push_back({RxPortCntl, RxPortData});
               else expOvf = 1'b1;
            end
         end
         if (wasInit) inInit = 1'b0;
         else if (oldOwner == 0) begin
            if (getPacketReq) owner = 1;
            else if (directCntlReq) owner = 2;
         end
      end
   endtask

   task automatic cycle();
      modelEdge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; getPacketReq = 1'b1;
      cycle();
      cycle();
      checks++; if (getPacketGnt !== 1'b0) begin failures++; $display("FAIL reset_gp_gnt actual=%0b expected=0", getPacketGnt); end
      checks++; if (directCntlGnt !== 1'b0) begin failures++; $display("FAIL reset_dc_gnt actual=%0b expected=0", directCntlGnt); end
      checks++; if ({getPacketRxValid, getPacketRxData, getPacketRxCntl} !== 17'h0) begin failures++;
         $display("FAIL reset_gp_rx actual=%0b/%h/%h expected=0/00/00", getPacketRxValid, getPacketRxData, getPacketRxCntl); end
      checks++; if ({directCntlRxValid, directCntlRxData, directCntlRxCntl} !== 17'h0) begin failures++;
         $display("FAIL reset_dc_rx actual=%0b/%h/%h expected=0/00/00", directCntlRxValid, directCntlRxData, directCntlRxCntl); end
      checks++; if (rxOverflow !== 1'b0) begin failures++; $display("FAIL reset_ovf actual=%0b expected=0", rxOverflow); end
      rst = 1'b0;
      cycle();
      checks++; if (getPacketGnt !== 1'b0) begin failures++; $display("FAIL init_no_gnt actual=%0b expected=0", getPacketGnt); end
      cycle();
      checks++; if (getPacketGnt !== 1'b1 || getPacketGnt !== (owner == 1)) begin failures++;
         $display("FAIL first_gnt actual=%0b expected=1", getPacketGnt); end
   endtask

   task automatic test_priority();
      getPacketReq = 1'b0;
      cycle();
      getPacketReq = 1'b1; directCntlReq = 1'b1;
      cycle();
      checks++; if ({getPacketGnt, directCntlGnt} !== 2'b10) begin failures++;
         $display("FAIL both_req_gnt actual=%b expected=10", {getPacketGnt, directCntlGnt}); end
      getPacketReq = 1'b0;
      cycle();
      checks++; if ({getPacketGnt, directCntlGnt} !== 2'b00) begin failures++;
         $display("FAIL release_gnt actual=%b expected=00", {getPacketGnt, directCntlGnt}); end
      cycle();
      checks++; if ({getPacketGnt, directCntlGnt} !== 2'b01) begin failures++;
         $display("FAIL dc_after_release actual=%b expected=01", {getPacketGnt, directCntlGnt}); end
      directCntlReq = 1'b0;
      cycle();
   endtask

   task automatic test_getpkt_stream();
      getPacketReq = 1'b1;
      cycle();
      RxPortDataValid = 1'b1; RxPortData = 8'hA5; RxPortCntl = 8'h01; getPacketRdEn = 1'b1;
      cycle();
      checks++; if ({getPacketRxValid, getPacketRxData, getPacketRxCntl} !== {1'b1, 8'hA5, 8'h01}) begin failures++;
         $display("FAIL stream_first actual=%0b/%h/%h expected=1/a5/01", getPacketRxValid, getPacketRxData, getPacketRxCntl); end
      checks++; if (directCntlRxValid !== 1'b0) begin failures++; $display("FAIL stream_dc_valid actual=%0b expected=0", directCntlRxValid); end
      RxPortData = 8'h3C; RxPortCntl = 8'h02;
      cycle();
      checks++; if ({getPacketRxValid, getPacketRxData, getPacketRxCntl} !== {1'b1, 8'h3C, 8'h02}) begin failures++;
         $display("FAIL stream_second actual=%0b/%h/%h expected=1/3c/02", getPacketRxValid, getPacketRxData, getPacketRxCntl); end
      checks++; if ({directCntlRxValid, directCntlRxData} !== 9'h0) begin failures++;
         $display("FAIL stream_dc_quiet actual=%0b/%h expected=0/00", directCntlRxValid, directCntlRxData); end
      RxPortDataValid = 1'b0;
      cycle();
      checks++; if (getPacketRxValid !== 1'b0) begin failures++; $display("FAIL stream_drained actual=%0b expected=0", getPacketRxValid); end
      getPacketRdEn = 1'b0;
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 5; i++) begin
         RxPortDataValid = 1'b1; RxPortData = 8'(i); RxPortCntl = 8'($urandom_range(0, 255));
         cycle();
      end
      RxPortDataValid = 1'b0;
      checks++; if (rxOverflow !== 1'b1 || expOvf !== 1'b1) begin failures++;
         $display("FAIL ovf_set actual=%0b expected=1", rxOverflow); end
      getPacketRdEn = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         checks++; if (getPacketRxData !== 8'(i) || getPacketRxCntl !== expCntl(1)) begin failures++;
            $display("FAIL ovf_pop%0d actual=%h/%h expected=%h/%h", i, getPacketRxData, getPacketRxCntl, 8'(i), expCntl(1)); end
         cycle();
      end
      checks++; if (getPacketRxValid !== 1'b0) begin failures++; $display("FAIL ovf_empty actual=%0b expected=0", getPacketRxValid); end
      checks++; if (rxOverflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky actual=%0b expected=1", rxOverflow); end
      getPacketRdEn = 1'b0; getPacketReq = 1'b0;
      cycle();
      checks++; if ({rxOverflow, getPacketGnt} !== 2'b00) begin failures++;
         $display("FAIL ovf_release actual=%b expected=00", {rxOverflow, getPacketGnt}); end
      getPacketReq = 1'b1;
      cycle();
      checks++; if ({getPacketGnt, getPacketRxValid} !== 2'b10) begin failures++;
         $display("FAIL ovf_regrant_empty actual=%b expected=10", {getPacketGnt, getPacketRxValid}); end
   endtask

   task automatic test_full_pushpop();
      for (int i = 0; i < 4; i++) begin
         RxPortDataValid = 1'b1; RxPortData = 8'h10 + 8'(i); RxPortCntl = 8'hC0 + 8'(i);
         cycle();
      end
      RxPortData = 8'h14; RxPortCntl = 8'hC4; getPacketRdEn = 1'b1;
      cycle();
      checks++; if ({rxOverflow, getPacketRxValid, getPacketRxData} !== {2'b01, 8'h11}) begin failures++;
         $display("FAIL full_pushpop actual=%0b/%0b/%h expected=0/1/11", rxOverflow, getPacketRxValid, getPacketRxData); end
      RxPortDataValid = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         checks++; if ({getPacketRxData, getPacketRxCntl} !== {8'h10 + 8'(i), 8'hC0 + 8'(i)}) begin failures++;
            $display("FAIL full_drain%0d actual=%h/%h expected=%h/%h", i, getPacketRxData, getPacketRxCntl, 8'h10 + 8'(i), 8'hC0 + 8'(i)); end
         cycle();
      end
      checks++; if (getPacketRxValid !== 1'b0) begin failures++; $display("FAIL full_drained actual=%0b expected=0", getPacketRxValid); end
      for (int k = 0; k < 10; k++) begin
         RxPortDataValid = 1'b1; RxPortData = 8'h20 + 8'(k); RxPortCntl = 8'($urandom_range(0, 255));
         cycle();
         checks++; if (getPacketRxData !== 8'h20 + 8'(k) || getPacketRxCntl !== expCntl(1)) begin failures++;
            $display("FAIL wrap%0d actual=%h/%h expected=%h/%h", k, getPacketRxData, getPacketRxCntl, 8'h20 + 8'(k), expCntl(1)); end
      end
      RxPortDataValid = 1'b0;
      cycle();
      getPacketRdEn = 1'b0; getPacketReq = 1'b0;
      cycle();
   endtask

   task automatic test_idle_strobe();
      RxPortDataValid = 1'b1; RxPortData = 8'h77; RxPortCntl = 8'h5A;
      cycle();
      RxPortDataValid = 1'b0; directCntlReq = 1'b1;
      cycle();
      checks++; if ({directCntlGnt, directCntlRxValid, directCntlRxData, directCntlRxCntl} !== {2'b11, 8'h77, 8'h5A}) begin failures++;
         $display("FAIL idle_kept actual=%0b/%0b/%h/%h expected=1/1/77/5a", directCntlGnt, directCntlRxValid, directCntlRxData, directCntlRxCntl); end
      checks++; if ({getPacketRxValid, getPacketRxData} !== 9'h0) begin failures++;
         $display("FAIL idle_gp_quiet actual=%0b/%h expected=0/00", getPacketRxValid, getPacketRxData); end
      directCntlReq = 1'b0; RxPortDataValid = 1'b1; RxPortData = 8'h88;
      cycle();
      RxPortDataValid = 1'b0; directCntlReq = 1'b1;
      cycle();
      checks++; if ({directCntlGnt, directCntlRxValid} !== 2'b10) begin failures++;
         $display("FAIL flush_discard actual=%b expected=10", {directCntlGnt, directCntlRxValid}); end
      directCntlReq = 1'b0;
      cycle();
   endtask

   task automatic test_reset_mid();
      getPacketReq = 1'b1;
      cycle();
      for (int i = 0; i < 3; i++) begin
         RxPortDataValid = 1'b1; RxPortData = 8'($urandom_range(0, 255));
         cycle();
      end
      rst = 1'b1;
      cycle();
      checks++; if ({getPacketGnt, getPacketRxValid, getPacketRxData, rxOverflow} !== 11'h0) begin failures++;
         $display("FAIL mid_reset actual=%0b/%0b/%h/%0b expected=0/0/00/0", getPacketGnt, getPacketRxValid, getPacketRxData, rxOverflow); end
      rst = 1'b0; RxPortDataValid = 1'b0;
      cycle();
      cycle();
      checks++; if ({getPacketGnt, getPacketRxValid} !== 2'b10) begin failures++;
         $display("FAIL mid_reset_empty actual=%b expected=10", {getPacketGnt, getPacketRxValid}); end
      getPacketReq = 1'b0;
      cycle();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         rst             = ($urandom_range(0, 49) == 0);
         RxPortDataValid = $urandom_range(0, 1);
         RxPortData      = 8'($urandom_range(0, 255));
         RxPortCntl      = 8'($urandom_range(0, 255));
         getPacketRdEn   = ($urandom_range(0, 2) != 0);
         directCntlRdEn  = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 7) == 0) getPacketReq  = ~getPacketReq;
         if ($urandom_range(0, 7) == 0) directCntlReq = ~directCntlReq;
         cycle();
         checks++; if ({getPacketGnt, directCntlGnt} !== {owner == 1, owner == 2}) begin failures++;
            $display("FAIL rnd_gnt n=%0d actual=%b expected=%b", n, {getPacketGnt, directCntlGnt}, {owner == 1, owner == 2}); end
         checks++; if ({getPacketRxValid, getPacketRxData, getPacketRxCntl} !== {expValid(1), expData(1), expCntl(1)}) begin failures++;
            $display("FAIL rnd_gp n=%0d actual=%0b/%h/%h expected=%0b/%h/%h", n, getPacketRxValid, getPacketRxData, getPacketRxCntl, expValid(1), expData(1), expCntl(1)); end
         checks++; if ({directCntlRxValid, directCntlRxData, directCntlRxCntl} !== {expValid(2), expData(2), expCntl(2)}) begin failures++;
            $display("FAIL rnd_dc n=%0d actual=%0b/%h/%h expected=%0b/%h/%h", n, directCntlRxValid, directCntlRxData, directCntlRxCntl, expValid(2), expData(2), expCntl(2)); end
         checks++; if (rxOverflow !== expOvf) begin failures++;
            $display("FAIL rnd_ovf n=%0d actual=%0b expected=%0b", n, rxOverflow, expOvf); end
      end
      rst = 1'b0; RxPortDataValid = 1'b0; getPacketReq = 1'b0; directCntlReq = 1'b0;
      getPacketRdEn = 1'b0; directCntlRdEn = 1'b0;
      cycle();
   endtask

   initial begin
      rst = 1'b1; RxPortData = 8'h00; RxPortCntl = 8'h00; RxPortDataValid = 1'b0;
      getPacketReq = 1'b0; getPacketRdEn = 1'b0; directCntlReq = 1'b0; directCntlRdEn = 1'b0;
      test_reset();
      test_priority();
      test_getpkt_stream();
      test_overflow();
      test_full_pushpop();
      test_idle_strobe();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
